// File: rtl/slug_io_pkg.sv
// Shared constants and types for the slug CPU board I/O.
package slug_io_pkg;

    localparam int unsigned SW_LSB          = 0;
    localparam int unsigned BTN_LSB         = 4;
    localparam int unsigned IO_W            = 8;
    localparam int unsigned DB_CYCLES_25MHZ = 250000;

    typedef logic [IO_W-1:0] io_word_t;

endpackage

// File: rtl/slug_debounce_bit.sv
// One conditioned input: polarity fix, two-flop synchroniser, debounce
// counter, registered rising-edge strobe and sticky rising-edge flag.
module slug_debounce_bit
    import slug_io_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_25MHZ,
    parameter logic        INV       = 1'b0
) (
    input  logic pclk,
    input  logic rst,
    input  logic raw,
    input  logic clr,
    output logic level,
    output logic rise_pulse,
    output logic rise_flag
);

    localparam int unsigned      CNT_W   = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             level_d;
    logic             accept;
    logic             rise_now;

    // Acceptance happens on the edge where a mismatch has persisted long enough.
    always_comb begin
        accept   = (s2 != level) && (cnt == CNT_MAX);
        rise_now = accept && s2;
    end

    // Polarity-corrected pin into a plain two-flop synchroniser.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw ^ INV;
            s2 <= s1;
        end
    end

    // Debounce: any cycle agreeing with the current level restarts the count.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (accept) begin
            level <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Strobe lags level by one edge; the flag is set on the accepting edge
    // itself and a simultaneous clear loses to the set.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            level_d    <= 1'b0;
            rise_pulse <= 1'b0;
            rise_flag  <= 1'b0;
        end else begin
            level_d    <= level;
            rise_pulse <= level & ~level_d;
            if (rise_now) begin
                rise_flag <= 1'b1;
            end else if (clr) begin
                rise_flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/slug_input_cond.sv
// Input conditioner for the slug CPU port_in word: WIDTH independent
// debounced inputs plus a registered "any event pending" summary.
module slug_input_cond
    import slug_io_pkg::*;
#(
    parameter int unsigned      WIDTH     = IO_W,
    parameter int unsigned      DB_CYCLES = DB_CYCLES_25MHZ,
    parameter logic [WIDTH-1:0] INVERT    = '0
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] rise_flag,
    output logic             any_rise
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        slug_debounce_bit #(
            .DB_CYCLES (DB_CYCLES),
            .INV       (INVERT[i])
        ) u_bit (
            .pclk       (pclk),
            .rst        (rst),
            .raw        (raw_in[i]),
            .clr        (clr[i]),
            .level      (level[i]),
            .rise_pulse (rise_pulse[i]),
            .rise_flag  (rise_flag[i])
        );
    end

    // Registered OR of the sticky flags, one cycle behind rise_flag.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            any_rise <= 1'b0;
        end else begin
            any_rise <= |rise_flag;
        end
    end

endmodule

// File: tb/tb_slug_input_cond.sv
// Directed bench for slug_input_cond with a cycle-tagged scoreboard.
module tb_slug_input_cond;
    import slug_io_pkg::*;

    localparam int unsigned DB    = 4;
    localparam int          DUT_A = 0;
    localparam int          DUT_B = 1;
    localparam int          F_LVL = 0;
    localparam int          F_PUL = 1;
    localparam int          F_FLG = 2;
    localparam int          F_ANY = 3;

    logic       pclk = 1'b0;
    logic       rst;
    logic [7:0] raw_a, clr_a, level_a, pulse_a, flag_a;
    logic [7:0] raw_b, clr_b, level_b, pulse_b, flag_b;
    logic       any_a, any_b;

    int unsigned edge_cnt = 0;
    int          checks   = 0;
    int          failures = 0;

    typedef struct {
        int unsigned cyc;
        int          dut;
        int          fld;
        logic [7:0]  exp;
        logic [7:0]  mask;
        string       name;
    } exp_t;

    exp_t sb[$];

    slug_input_cond #(
        .WIDTH     (IO_W),
        .DB_CYCLES (DB),
        .INVERT    (8'h00)
    ) dut_a (
        .pclk       (pclk),
        .rst        (rst),
        .raw_in     (raw_a),
        .clr        (clr_a),
        .level      (level_a),
        .rise_pulse (pulse_a),
        .rise_flag  (flag_a),
        .any_rise   (any_a)
    );

    slug_input_cond #(
        .WIDTH     (IO_W),
        .DB_CYCLES (DB),
        .INVERT    (8'hF0)
    ) dut_b (
        .pclk       (pclk),
        .rst        (rst),
        .raw_in     (raw_b),
        .clr        (clr_b),
        .level      (level_b),
        .rise_pulse (pulse_b),
        .rise_flag  (flag_b),
        .any_rise   (any_b)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) edge_cnt <= edge_cnt + 1;

    function automatic logic [7:0] actual(int dut, int fld);
        logic [7:0] v;
        v = 8'h00;
        if (dut == DUT_A) begin
            case (fld)
                F_LVL:   v = level_a;
                F_PUL:   v = pulse_a;
                F_FLG:   v = flag_a;
                default: v = {7'b0, any_a};
            endcase
        end else begin
            case (fld)
                F_LVL:   v = level_b;
                F_PUL:   v = pulse_b;
                F_FLG:   v = flag_b;
                default: v = {7'b0, any_b};
            endcase
        end
        return v;
    endfunction

    task automatic exp_at(int unsigned cyc, int dut, int fld,
                          logic [7:0] exp, logic [7:0] mask, string name);
        exp_t e;
        e.cyc  = cyc;
        e.dut  = dut;
        e.fld  = fld;
        e.exp  = exp;
        e.mask = mask;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic exp_all_zero(int dut, string name);
        for (int f = 0; f < 4; f++) exp_at(edge_cnt, dut, f, 8'h00, 8'hFF, name);
    endtask

    task automatic wait_neg(int unsigned n);
        repeat (n) @(negedge pclk);
    endtask

    // Monitor: settles after each falling edge and retires due entries.
    initial begin
        logic [7:0] act;
        forever begin
            @(negedge pclk);
            #2;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == edge_cnt) begin
                    act = actual(sb[i].dut, sb[i].fld);
                    checks++;
                    if ((act & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
                        failures++;
                        $display("FAIL %s dut=%0d fld=%0d cyc=%0d got=%02h exp=%02h mask=%02h",
                                 sb[i].name, sb[i].dut, sb[i].fld, edge_cnt,
                                 act, sb[i].exp, sb[i].mask);
                    end
                    sb.delete(i);
                end else if (sb[i].cyc < edge_cnt) begin
                    checks++;
                    failures++;
                    $display("FAIL %s missed cyc=%0d now=%0d", sb[i].name, sb[i].cyc, edge_cnt);
                    sb.delete(i);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int unsigned b, c, d, e, f, g, h, r, m;
        rst   = 1'b0;
        raw_a = 8'h00;
        clr_a = 8'h00;
        raw_b = 8'hF0;
        clr_b = 8'h00;

        @(negedge pclk);
        exp_all_zero(DUT_A, "reset_a");
        exp_all_zero(DUT_B, "reset_b");
        wait_neg(1);
        rst = 1'b1;
        wait_neg(2);

        // Rise on bit 0, full latency chain.
        b = edge_cnt;
        raw_a = 8'h01;
        exp_at(b+5, DUT_A, F_LVL, 8'h00, 8'hFF, "t1_level_early");
        exp_at(b+6, DUT_A, F_LVL, 8'h01, 8'hFF, "t1_level");
        exp_at(b+6, DUT_A, F_PUL, 8'h00, 8'hFF, "t1_pulse_early");
        exp_at(b+7, DUT_A, F_PUL, 8'h01, 8'hFF, "t1_pulse");
        exp_at(b+8, DUT_A, F_PUL, 8'h00, 8'hFF, "t1_pulse_end");
        exp_at(b+5, DUT_A, F_FLG, 8'h00, 8'hFF, "t1_flag_early");
        exp_at(b+6, DUT_A, F_FLG, 8'h01, 8'hFF, "t1_flag");
        exp_at(b+6, DUT_A, F_ANY, 8'h00, 8'h01, "t1_any_early");
        exp_at(b+7, DUT_A, F_ANY, 8'h01, 8'h01, "t1_any");
        exp_at(b+10, DUT_B, F_LVL, 8'h00, 8'hFF, "inv_hold");
        wait_neg(10);

        // Three-cycle glitch must not be accepted.
        c = edge_cnt;
        raw_a = 8'h00;
        for (int unsigned k = 1; k <= 10; k++) begin
            exp_at(c+k, DUT_A, F_LVL, 8'h01, 8'h01, "t2_glitch_level");
            exp_at(c+k, DUT_A, F_PUL, 8'h00, 8'hFF, "t2_glitch_pulse");
        end
        wait_neg(3);
        raw_a = 8'h01;
        wait_neg(7);

        // Held low: falling edge, no strobe, flag untouched.
        d = edge_cnt;
        raw_a = 8'h00;
        exp_at(d+5, DUT_A, F_LVL, 8'h01, 8'hFF, "t2_fall_early");
        exp_at(d+6, DUT_A, F_LVL, 8'h00, 8'hFF, "t2_fall");
        for (int unsigned k = 5; k <= 8; k++)
            exp_at(d+k, DUT_A, F_PUL, 8'h00, 8'hFF, "t2_fall_pulse");
        exp_at(d+8, DUT_A, F_FLG, 8'h01, 8'hFF, "t2_flag_kept");
        wait_neg(8);

        // Inverted instance: pins going low read as rising levels.
        h = edge_cnt;
        raw_b = 8'h00;
        exp_at(h+5, DUT_B, F_LVL, 8'h00, 8'hFF, "inv_level_early");
        exp_at(h+6, DUT_B, F_LVL, 8'hF0, 8'hFF, "inv_level");
        exp_at(h+6, DUT_B, F_FLG, 8'hF0, 8'hFF, "inv_flag");
        exp_at(h+7, DUT_B, F_PUL, 8'hF0, 8'hFF, "inv_pulse");
        exp_at(h+7, DUT_B, F_ANY, 8'h01, 8'h01, "inv_any");
        wait_neg(8);

        // Flag clear on bit 1, then bit 0; any_rise follows one cycle late.
        e = edge_cnt;
        raw_a = 8'h02;
        exp_at(e+5,  DUT_A, F_FLG, 8'h01, 8'hFF, "t3_flag_early");
        exp_at(e+6,  DUT_A, F_FLG, 8'h03, 8'hFF, "t3_flag_set");
        exp_at(e+6,  DUT_A, F_LVL, 8'h02, 8'hFF, "t3_level");
        exp_at(e+8,  DUT_A, F_FLG, 8'h03, 8'hFF, "t3_flag_before_clr");
        exp_at(e+9,  DUT_A, F_FLG, 8'h01, 8'hFF, "t3_flag_clr1");
        exp_at(e+10, DUT_A, F_FLG, 8'h01, 8'hFF, "t3_flag_clr_released");
        exp_at(e+11, DUT_A, F_FLG, 8'h00, 8'hFF, "t3_flag_clr0");
        exp_at(e+11, DUT_A, F_ANY, 8'h01, 8'h01, "t3_any_lag");
        exp_at(e+12, DUT_A, F_ANY, 8'h00, 8'h01, "t3_any_clear");
        wait_neg(8);
        clr_a = 8'h02;
        wait_neg(1);
        clr_a = 8'h00;
        wait_neg(1);
        clr_a = 8'h01;
        wait_neg(1);
        clr_a = 8'h00;
        wait_neg(1);

        // Bit 1 back to 0, then rise with clr on the accepting edge.
        f = edge_cnt;
        raw_a = 8'h00;
        exp_at(f+5, DUT_A, F_LVL, 8'h02, 8'h02, "t3_fall_early");
        exp_at(f+6, DUT_A, F_LVL, 8'h00, 8'h02, "t3_fall");
        wait_neg(8);
        g = edge_cnt;
        raw_a = 8'h02;
        exp_at(g+5, DUT_A, F_FLG, 8'h00, 8'hFF, "t3_set_early");
        exp_at(g+6, DUT_A, F_FLG, 8'h02, 8'hFF, "t3_set_wins");
        exp_at(g+7, DUT_A, F_FLG, 8'h02, 8'hFF, "t3_set_holds");
        exp_at(g+7, DUT_A, F_PUL, 8'h02, 8'hFF, "t3_pulse");
        exp_at(g+6, DUT_A, F_ANY, 8'h00, 8'h01, "t3_any_early");
        exp_at(g+7, DUT_A, F_ANY, 8'h01, 8'h01, "t3_any_set");
        wait_neg(5);
        clr_a = 8'h02;
        wait_neg(1);
        clr_a = 8'h00;
        wait_neg(4);

        // Reset in the middle of a count, asserted between edges.
        raw_a = 8'hFF;
        wait_neg(3);
        @(posedge pclk);
        #1;
        rst = 1'b0;
        exp_all_zero(DUT_A, "rst_mid_a");
        exp_all_zero(DUT_B, "rst_mid_b");
        @(negedge pclk);
        r = edge_cnt;
        rst = 1'b1;
        exp_at(r+5, DUT_A, F_LVL, 8'h00, 8'hFF, "t5_level_early");
        exp_at(r+6, DUT_A, F_LVL, 8'hFF, 8'hFF, "t5_level");
        exp_at(r+6, DUT_A, F_FLG, 8'hFF, 8'hFF, "t5_flag");
        exp_at(r+7, DUT_A, F_PUL, 8'hFF, 8'hFF, "t5_pulse");
        exp_at(r+6, DUT_A, F_ANY, 8'h00, 8'h01, "t5_any_early");
        exp_at(r+7, DUT_A, F_ANY, 8'h01, 8'h01, "t5_any");
        exp_at(r+5, DUT_B, F_LVL, 8'h00, 8'hFF, "t5_inv_early");
        exp_at(r+6, DUT_B, F_LVL, 8'hF0, 8'hFF, "t5_inv_level");
        wait_neg(10);

        // Bit 2 toggling every cycle never settles.
        m = edge_cnt;
        for (int unsigned k = 0; k < 50; k++) begin
            raw_a[2] = ~raw_a[2];
            exp_at(edge_cnt+2, DUT_A, F_LVL, 8'hFF, 8'hFF, "t6_level");
            exp_at(edge_cnt+2, DUT_A, F_PUL, 8'h00, 8'hFF, "t6_pulse");
            wait_neg(1);
        end
        exp_at(m+55, DUT_A, F_LVL, 8'hFF, 8'hFF, "t6_level_after");
        wait_neg(6);

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge pclk);
        #5;
        if (sb.size() != 0) begin
            checks   += sb.size();
            failures += sb.size();
            $display("FAIL scoreboard_drain left=%0d", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
